gf2_poly_div_seq: RTL and testbench

//  Sequential carry-less (GF(2)[x]) polynomial divider: the inverse operation of the OKA multipliers.

---
 rtl/gf2_div_pkg.sv | 20 ++
 rtl/gf2_degree.sv | 25 ++
 rtl/gf2_poly_div_seq.sv | 146 ++++++++++++++
 tb/tb_gf2_poly_div_seq.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gf2_div_pkg.sv
// Shared types and default sizes for the sequential GF(2)[x] polynomial divider.
//   GF2_N : default divisor width
//   AW    : dividend / quotient width (2N-1)
//   RW    : remainder width (N-1)
//   CW    : bit counter / dividend degree width
//   gf2_div_state_e : divider FSM states
package gf2_div_pkg;

  localparam int GF2_N = 12;
  localparam int AW    = 2 * GF2_N - 1;
  localparam int RW    = GF2_N - 1;
  localparam int CW    = $clog2(2 * GF2_N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } gf2_div_state_e;

endpackage

// File: rtl/gf2_degree.sv
// Combinational degree finder for a GF(2) polynomial: index of the highest
// set bit, plus a zero flag. deg is 0 when vec is zero.
//   vec  : polynomial, bit i = coefficient of x^i
//   deg  : index of the most significant set bit
//   zero : vec has no set bits
module gf2_degree #(
  parameter int W  = 12,
  parameter int DW = 4
) (
  input  logic [W-1:0]  vec,
  output logic [DW-1:0] deg,
  output logic          zero
);

  // Ascending scan: the last set bit seen is the MSB.
  always_comb begin
    deg = '0;
    for (int i = 0; i < W; i++) begin
      if (vec[i]) deg = DW'(i);
    end
  end

  assign zero = ~|vec;

endmodule

// File: rtl/gf2_poly_div_seq.sv
// Sequential carry-less (GF(2)[x]) polynomial divider, bit-serial long
// division MSB first, one dividend bit per RUN cycle.
//
// Optional build macro GF2DIV_SKIP_LZ_EN: start the bit counter at deg(A)
// instead of 2N-2, skipping the dividend's leading zeros. Results are
// identical; only latency changes.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high only in IDLE; out_valid is high only in DONE and
// the result is held stable until out_ready is seen.
//
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   in_valid    : dividend/divisor offered
//   in_ready    : divider idle and able to accept
//   dividend    : A, 2N-1 bits
//   divisor     : D, N bits
//   out_valid   : result available
//   out_ready   : consumer takes the result
//   quotient    : Q with A = Q*D ^ R
//   remainder   : R with deg(R) < deg(D)
//   div_by_zero : D was zero (Q = R = 0)
//   state_dbg   : current FSM state
module gf2_poly_div_seq
  import gf2_div_pkg::*;
#(
  parameter int N = GF2_N
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2*N-2:0]   dividend,
  input  logic [N-1:0]     divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*N-2:0]   quotient,
  output logic [N-2:0]     remainder,
  output logic             div_by_zero,
  output gf2_div_state_e   state_dbg
);

  localparam int A_W  = 2 * N - 1;
  localparam int R_W  = N - 1;
  localparam int C_W  = $clog2(2 * N - 1);
  localparam int DG_W = $clog2(N);

  gf2_div_state_e state, state_next;

  logic [A_W-1:0]  a_reg;
  logic [N-1:0]    d_reg;
  logic [DG_W-1:0] dg_reg;
  logic [R_W-1:0]  r_reg;
  logic [A_W-1:0]  q_reg;
  logic [C_W-1:0]  cnt;
  logic            dbz_reg;

  logic [DG_W-1:0] d_deg;
  logic            d_zero;
  logic [C_W-1:0]  cnt_start;

  logic [N-1:0]    t;
  logic [R_W-1:0]  r_step;
  logic            q_bit;

  gf2_degree #(.W(N), .DW(DG_W)) u_deg_d (
    .vec  (divisor),
    .deg  (d_deg),
    .zero (d_zero)
  );

`ifdef GF2DIV_SKIP_LZ_EN
  logic [C_W-1:0] a_deg;
  logic           a_zero;

  gf2_degree #(.W(A_W), .DW(C_W)) u_deg_a (
    .vec  (dividend),
    .deg  (a_deg),
    .zero (a_zero)
  );

  assign cnt_start = a_zero ? '0 : a_deg;
`else
  assign cnt_start = C_W'(A_W - 1);
`endif

  // One long-division step: shift the next dividend bit into the partial
  // remainder; if the bit at the divisor's degree is set, subtract (XOR) D.
  // Since deg(R) < dg before the step, t[N-1] is always cleared by the XOR,
  // so dropping it loses nothing.
  always_comb begin
    t = {r_reg, a_reg[cnt]};
    q_bit = t[dg_reg];
    if (q_bit) t = t ^ d_reg;
    r_step = t[R_W-1:0];
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (in_valid) state_next = RUN;
      // A zero divisor spends one cycle here without stepping.
      RUN:  if (dbz_reg || cnt == '0) state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      a_reg   <= '0;
      d_reg   <= '0;
      dg_reg  <= '0;
      r_reg   <= '0;
      q_reg   <= '0;
      cnt     <= '0;
      dbz_reg <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE && in_valid) begin
        a_reg   <= dividend;
        d_reg   <= divisor;
        dg_reg  <= d_deg;
        r_reg   <= '0;
        q_reg   <= '0;
        cnt     <= cnt_start;
        dbz_reg <= d_zero;
      end else if (state == RUN && !dbz_reg) begin
        // Quotient bits arrive MSB first, so shifting left lands each at
        // its proper index once the final (i=0) step is done.
        r_reg <= r_step;
        q_reg <= {q_reg[A_W-2:0], q_bit};
        cnt   <= cnt - 1'b1;
      end
    end
  end

  assign in_ready    = (state == IDLE);
  assign out_valid   = (state == DONE);
  assign quotient    = q_reg;
  assign remainder   = r_reg;
  assign div_by_zero = dbz_reg;
  assign state_dbg   = state;

endmodule

// File: tb/tb_gf2_poly_div_seq.sv
// Bench for gf2_poly_div_seq (N=12): directed vectors, backpressure, reset
// during RUN, and randomized operations against a behavioural long-division
// model plus an A == Q*D ^ R product check.
module tb_gf2_poly_div_seq;
  import gf2_div_pkg::*;

  localparam int N   = 12;
  localparam int A_W = 2 * N - 1;
  localparam int R_W = N - 1;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [A_W-1:0] dividend = '0;
  logic [N-1:0]   divisor = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [A_W-1:0] quotient;
  logic [R_W-1:0] remainder;
  logic           div_by_zero;
  gf2_div_state_e state_dbg;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  gf2_poly_div_seq #(.N(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .state_dbg   (state_dbg)
  );

  // ---------------- reference model ----------------
  function automatic int deg_of(input logic [A_W-1:0] v);
    int k = 0;
    for (int i = 0; i < A_W; i++) if (v[i]) k = i;
    return k;
  endfunction

  // Textbook polynomial long division: cancel the leading term of the
  // running remainder with a shifted copy of D.
  task automatic ref_div(input logic [A_W-1:0] a, input logic [N-1:0] d,
                         output logic [A_W-1:0] q, output logic [R_W-1:0] r,
                         output logic dbz);
    logic [A_W-1:0] rem;
    logic [A_W-1:0] dd;
    int dg;
    q = '0;
    r = '0;
    dbz = (d == '0);
    if (!dbz) begin
      dd  = A_W'(d);
      dg  = deg_of(dd);
      rem = a;
      for (int i = A_W - 1; i >= dg; i--) begin
        if (rem[i]) begin
          rem = rem ^ (dd << (i - dg));
          q[i - dg] = 1'b1;
        end
      end
      r = rem[R_W-1:0];
    end
  endtask

  function automatic logic [A_W+N-2:0] clmul(input logic [A_W-1:0] q, input logic [N-1:0] d);
    logic [A_W+N-2:0] res = '0;
    for (int i = 0; i < N; i++)
      if (d[i]) res = res ^ ((A_W+N-1)'(q) << i);
    return res;
  endfunction

  function automatic int exp_latency(input logic [A_W-1:0] a, input logic [N-1:0] d);
    if (d == '0) return 2;
`ifdef GF2DIV_SKIP_LZ_EN
    return deg_of(a) + 2;
`else
    return 2 * N;
`endif
  endfunction

  // ---------------- driver helpers ----------------
  // Presents one operation, waits for the accepting edge, returns #1 after it.
  task automatic start_op(input logic [A_W-1:0] a, input logic [N-1:0] d);
    int guard = 0;
    dividend = a;
    divisor  = d;
    in_valid = 1'b1;
    while (!in_ready && guard < 100) begin
      @(posedge clk); #1; guard++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Waits for out_valid counting the accept cycle as cycle 1.
  task automatic wait_result(output int lat);
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic take_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  // Full operation with all result checks; leaves the block idle.
  task automatic run_op(input string name, input logic [A_W-1:0] a, input logic [N-1:0] d,
                        input bit chk_lat);
    logic [A_W-1:0] eq;
    logic [R_W-1:0] er;
    logic edbz;
    int lat;
    ref_div(a, d, eq, er, edbz);
    start_op(a, d);
    wait_result(lat);
    n_vec++;
    if (out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL %s timeout: out_valid=%b required=1", name, out_valid);
    end
    if (chk_lat) begin
      n_vec++;
      if (lat !== exp_latency(a, d)) begin
        n_err++;
        $display("FAIL %s latency: got=%0d required=%0d", name, lat, exp_latency(a, d));
      end
    end
    n_vec++;
    if (quotient !== eq || remainder !== er || div_by_zero !== edbz) begin
      n_err++;
      $display("FAIL %s result A=%h D=%h: Q=%h R=%h dbz=%b required Q=%h R=%h dbz=%b",
               name, a, d, quotient, remainder, div_by_zero, eq, er, edbz);
    end
    if (d != '0) begin
      n_vec++;
      if ((clmul(quotient, d) ^ (A_W+N-1)'(remainder)) !== (A_W+N-1)'(a) ||
          (remainder != '0 && deg_of(A_W'(remainder)) >= deg_of(A_W'(d)))) begin
        n_err++;
        $display("FAIL %s identity A=%h D=%h: Q=%h R=%h does not satisfy A=Q*D^R, degR<degD",
                 name, a, d, quotient, remainder);
      end
    end
    take_result();
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL %s ready_after: in_ready=%b required=1", name, in_ready);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || quotient !== '0 ||
        remainder !== '0 || div_by_zero !== 1'b0 || state_dbg !== IDLE) begin
      n_err++;
      $display("FAIL reset: rdy=%b vld=%b Q=%h R=%h dbz=%b st=%0d required 1 0 0 0 0 IDLE",
               in_ready, out_valid, quotient, remainder, div_by_zero, state_dbg);
    end
  endtask

  task automatic test_directed();
    run_op("t1_0F_by_3", 23'h00000F, 12'h003, 1'b1);
    run_op("t2_13_by_3", 23'h000013, 12'h003, 1'b1);
    run_op("t3_all1_by_1", 23'h7FFFFF, 12'h001, 1'b1);
    run_op("t3_div_zero", 23'h123456, 12'h000, 1'b1);
    run_op("top_divisor", 23'h7A5C31, 12'h801, 1'b1);
    run_op("zero_dividend", 23'h000000, 12'h0B5, 1'b1);
  endtask

  task automatic test_backpressure();
    logic [A_W-1:0] hq;
    logic [R_W-1:0] hr;
    logic hdbz;
    int lat;
    bit stable = 1'b1;
    bit blocked = 1'b1;
    start_op(23'h000013, 12'h003);
    wait_result(lat);
    hq = quotient; hr = remainder; hdbz = div_by_zero;
    for (int k = 0; k < 10; k++) begin
      in_valid = k[0];
      dividend = 23'($urandom);
      divisor  = 12'($urandom);
      @(posedge clk); #1;
      if (quotient !== hq || remainder !== hr || div_by_zero !== hdbz || out_valid !== 1'b1) stable = 1'b0;
      if (in_ready !== 1'b0) blocked = 1'b0;
    end
    in_valid = 1'b0;
    n_vec++;
    if (!stable || hq !== 23'h00000E || hr !== 11'h001) begin
      n_err++;
      $display("FAIL backpressure_hold: Q=%h R=%h stable=%b required Q=00000e R=001 stable=1",
               quotient, remainder, stable);
    end
    n_vec++;
    if (!blocked) begin
      n_err++;
      $display("FAIL backpressure_ready: in_ready rose in DONE, required 0");
    end
    take_result();
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL backpressure_release: rdy=%b vld=%b required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_mid_run();
    bit quiet = 1'b1;
    start_op(23'h00000F, 12'h003);
    for (int k = 1; k < 7; k++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) quiet = 1'b0;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_vec++;
    if (state_dbg !== IDLE || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL midrun_reset: st=%0d rdy=%b vld=%b required IDLE 1 0",
               state_dbg, in_ready, out_valid);
    end
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) quiet = 1'b0;
    end
    n_vec++;
    if (!quiet) begin
      n_err++;
      $display("FAIL midrun_quiet: out_valid=1 seen for discarded op, required 0");
    end
    run_op("after_reset", 23'h00000F, 12'h003, 1'b1);
  endtask

  task automatic test_random();
    logic [A_W-1:0] a;
    logic [N-1:0] d;
    int mode;
    for (int k = 0; k < 600; k++) begin
      a = 23'($urandom);
      if ($urandom_range(0, 3) == 0) a = a >> $urandom_range(0, 22);
      mode = $urandom_range(0, 9);
      case (mode)
        0: d = '0;
        1: d = 12'h001;
        2: d = 12'h800 | 12'($urandom);
        3: d = 12'($urandom_range(2, 15));
        default: d = 12'($urandom);
      endcase
      run_op("random", a, d, 1'b1);
    end
  endtask

  task automatic test_back_to_back();
    // Result taken the cycle it appears, next op offered immediately.
    run_op("b2b_0", 23'h5A5A5A, 12'h1F3, 1'b1);
    run_op("b2b_1", 23'h400000, 12'h002, 1'b1);
    run_op("b2b_2", 23'h000001, 12'hFFF, 1'b1);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
